// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch over a req/ack memory port, FIFO of {pc, instr}, redirect flush.
// Optional same-cycle ack-to-output bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [31:0]   fetch_pc;
    logic [31:0]   drop_addr;
    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] cnt;

    logic ack_v;
    logic fifo_pop;
    logic push;
    logic byp;
    logic byp_take;
    entry_t head;

    assign head     = mem[rd_ptr];
    assign fifo_pop = (cnt != '0) && out_ready && !redirect;
    assign ack_v    = imem_req && imem_ack;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp = (cnt == '0) && (state == FETCH) && ack_v && !redirect;
`else
    assign byp = 1'b0;
`endif

    // A bypassed word taken by IF/ID never enters the buffer.
    assign byp_take  = byp && out_ready;
    assign push      = (state == FETCH) && ack_v && !redirect && !byp_take;

    assign out_valid = (cnt != '0) || byp;
    assign out_pc    = byp ? fetch_pc   : head.pc;
    assign out_instr = byp ? imem_rdata : head.instr;
    assign count     = cnt;

    always_comb begin
        state_nx  = state;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        case (state)
            FETCH: begin
                // A pop frees a slot this cycle, so a full queue may still issue.
                imem_req = !rst && ((cnt < DEPTH_C) || fifo_pop);
                if (redirect && imem_req && !imem_ack)
                    state_nx = DROP;
            end
            DROP: begin
                // The abandoned request stays on the bus until memory answers it.
                imem_req  = !rst;
                imem_addr = drop_addr;
                if (ack_v)
                    state_nx = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            drop_addr <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nx;
            if (state == FETCH && state_nx == DROP)
                drop_addr <= fetch_pc;
            if (redirect) begin
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                cnt      <= '0;
                fetch_pc <= redirect_pc & ~32'h3;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (fifo_pop)
                    rd_ptr <= rd_ptr + PW'(1);
                if (push && !fifo_pop)
                    cnt <= cnt + CW'(1);
                else if (!push && fifo_pop)
                    cnt <= cnt - CW'(1);
                if (state == FETCH && ack_v)
                    fetch_pc <= fetch_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rdata};
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios then random traffic against a queue-based reference model.
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    int total = 0;
    int bad   = 0;

    // reference model
    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_drop;
    logic [31:0] m_drop_addr;

    // memory responder
    bit          busy;
    int          waited;
    int          lat;
    int          lat_fix = 0;
    bit          spur_en = 0;
    bit          force_en = 0;
    logic [31:0] force_val = '0;
    bit          rst_held = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        bit          e_req, ack_v, byp, popped;
        logic [31:0] e_addr;
        ent_t        e;
        @(negedge clk);
        rst = r; redirect = rd; redirect_pc = rpc; out_ready = rdy; imem_ack = 1'b0;
        #1;
        if (!r && !busy && imem_req) begin
            busy = 1; waited = 0;
            lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        end
        if (busy) imem_ack = (waited == lat);
        else      imem_ack = spur_en && ($urandom_range(0, 3) == 0);
        imem_rdata = force_en ? force_val : $urandom;
        #1;
        if (r) begin
            check("rst_req", imem_req, 0);
            if (rst_held) begin
                check("rst_count", count, 0);
                check("rst_valid", out_valid, 0);
            end
            rst_held = 1; busy = 0;
            q.delete(); m_pc = 32'h100; m_drop = 0; m_drop_addr = '0;
        end else begin
            rst_held = 0;
            e_req  = m_drop || (q.size() < DEPTH) || (q.size() > 0 && rdy && !rd);
            e_addr = m_drop ? m_drop_addr : m_pc;
            ack_v  = e_req && imem_ack;
`ifdef FETCH_QUEUE_BYPASS_EN
            byp = (q.size() == 0) && !m_drop && ack_v && !rd;
`else
            byp = 0;
`endif
            check("req", imem_req, e_req);
            if (e_req) check("addr", imem_addr, e_addr);
            check("count", count, q.size());
            check("valid", out_valid, (q.size() > 0) || byp);
            if (byp) begin
                check("byp_pc", out_pc, m_pc);
                check("byp_instr", out_instr, imem_rdata);
            end else if (q.size() > 0) begin
                check("pc", out_pc, q[0].pc);
                check("instr", out_instr, q[0].instr);
            end
            // next state of the model
            if (rd) begin
                q.delete();
                if (!m_drop && e_req && !imem_ack) begin
                    m_drop = 1; m_drop_addr = m_pc;
                end else if (m_drop && ack_v) begin
                    m_drop = 0;
                end
                m_pc = rpc & ~32'h3;
            end else if (m_drop) begin
                if (ack_v) m_drop = 0;
            end else begin
                popped = (q.size() > 0) && rdy;
                if (popped) void'(q.pop_front());
                if (ack_v) begin
                    if (!(byp && rdy)) begin
                        e.pc = m_pc; e.instr = imem_rdata;
                        q.push_back(e);
                    end
                    m_pc = m_pc + 32'd4;
                end
            end
            if (busy) begin
                if (imem_ack) busy = 0;
                else          waited++;
            end
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
    endtask

    initial begin
        rst = 1; redirect = 0; redirect_pc = '0; out_ready = 0; imem_ack = 0; imem_rdata = '0;
        busy = 0; waited = 0; lat = 0;

        // zero-wait streaming with IF/ID always ready
        do_reset();
        lat_fix = 0;
        repeat (10) step(0, 0, 0, 1);

        // fill to DEPTH with a stalled consumer, then one pop
        do_reset();
        repeat (6) step(0, 0, 0, 0);
        check("full_count", count, 4);
        step(0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0);

        // 3-cycle memory, redirect in the second wait cycle
        do_reset();
        lat_fix = 3;
        step(0, 0, 0, 1);
        step(0, 1, 32'h200, 1);
        repeat (10) step(0, 0, 0, 1);

        // redirect coinciding with an ack, two entries queued
        do_reset();
        lat_fix = 0;
        repeat (2) step(0, 0, 0, 0);
        step(0, 1, 32'h300, 0);
        repeat (3) step(0, 0, 0, 1);

        // address wrap at the top of the space
        do_reset();
        step(0, 1, 32'hFFFF_FFFC, 1);
        repeat (4) step(0, 0, 0, 1);

`ifdef FETCH_QUEUE_BYPASS_EN
        do_reset();
        force_en = 1; force_val = 32'h0050_0093;
        step(0, 0, 0, 1);
        force_en = 0;
        repeat (3) step(0, 0, 0, 1);
`endif

        // random traffic, latencies and redirects, with stray acks while idle
        do_reset();
        lat_fix = -1;
        spur_en = 1;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 399) == 0),
                 ($urandom_range(0, 19) == 0),
                 $urandom,
                 ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
